cpu4_mc_datapath: RTL and testbench
===================================

CPU4_MC_DATAPATH -- requirements
Module: cpu4_mc_datapath

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL provide parameter HALT_ON_ILLEGAL, default 1, meaning 1 = halt on an unsupported instruction, 0 = treat it as a NOP.
REQ-003 The block SHALL provide parameter NREGS, default 32 (legal values 8, 16 or 32), meaning the register-file depth; register index bits at and above log2(NREGS) are ignored.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 mem_req  output  1  memory request valid.
REQ-007 mem_we  output  1  1 = write, 0 = read; meaningful only while mem_req=1.
REQ-008 mem_addr  output  32  byte address.
REQ-009 mem_wdata  output  32  store data.
REQ-010 mem_rdata  input  32  read data; sampled only in the cycle where mem_req=1, mem_we=0 and mem_ready=1.
REQ-011 mem_ready  input  1  completes the current request; ignored while mem_req=0.
REQ-012 pc  output  32  current program counter.
REQ-013 state  output  4  current FSM state encoding, for debug.
REQ-014 halted  output  1  high while in state HALT.

Function
REQ-015 The block SHALL implement a multicycle MIPS subset with a single shared memory port and these internal registers: PC, IR, A, B, ALUOUT and MDR; it SHALL contain no combinational path from mem_rdata or mem_ready to any output.
REQ-016 Supported instructions SHALL be lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, and R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; every other opcode or funct is illegal.
REQ-017 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
REQ-018 FETCH SHALL drive mem_req=1, mem_we=0 and mem_addr=PC. On mem_ready it SHALL load IR<=mem_rdata and PC<=PC+4 and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-019 DECODE SHALL load A<=rf[rs], B<=rf[rt] and ALUOUT<=PC+(signext(imm16)<<2), then go to MEMADR (lw/sw), EXEC (R-type with legal funct), BRANCH, ADDIEX or JUMP.
REQ-020 On an illegal instruction, DECODE SHALL go to HALT if HALT_ON_ILLEGAL=1, otherwise to FETCH with no architectural change.
REQ-021 MEMADR SHALL load ALUOUT<=A+signext(imm16), then go to MEMRD (lw) or MEMWR (sw).
REQ-022 MEMRD SHALL drive mem_req=1, mem_we=0 and mem_addr=ALUOUT. On mem_ready it SHALL load MDR<=mem_rdata and go to MEMWB.
REQ-023 MEMWB SHALL write rf[rt]<=MDR, then go to FETCH.
REQ-024 MEMWR SHALL drive mem_req=1, mem_we=1, mem_addr=ALUOUT and mem_wdata=B. On mem_ready it SHALL go to FETCH.
REQ-025 EXEC SHALL load ALUOUT<=A op B, then go to ALUWB. slt is signed and yields 32'd1 or 32'd0. All arithmetic is modulo 2^32 with no overflow trap.
REQ-026 ALUWB SHALL write rf[rd]<=ALUOUT, then go to FETCH.
REQ-027 BRANCH SHALL load PC<=ALUOUT when A==B, otherwise leave PC unchanged, then go to FETCH.
REQ-028 ADDIEX SHALL load ALUOUT<=A+signext(imm16), then go to ADDIWB; ADDIWB SHALL write rf[rt]<=ALUOUT, then go to FETCH.
REQ-029 JUMP SHALL load PC<={PC[31:28], IR[25:0], 2'b00}, then go to FETCH.
REQ-030 HALT SHALL be terminal until reset: mem_req=0, and no register or PC updates.
REQ-031 Register 0 SHALL always read 0; writes to it are discarded.
REQ-032 While mem_req=1, mem_addr, mem_we and mem_wdata SHALL be held stable until the cycle mem_ready=1 is sampled.
REQ-033 mem_req SHALL be 0 in every state other than FETCH, MEMRD and MEMWR. In those states, mem_wdata is don't-care when mem_we=0.
REQ-034 With zero-wait memory, latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each cycle with mem_ready=0 in a memory state adds exactly 1 cycle.
REQ-035 mem_ready may be held high continuously; back-to-back transactions SHALL then proceed with no idle cycle between FETCH completions other than the intervening states.
REQ-036 PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0). Branch targets SHALL use the already-incremented PC.

Reset
REQ-037 resetn=0 SHALL immediately set state=FETCH, PC=RESET_PC, IR=A=B=ALUOUT=MDR=0, all registers=0 and halted=0.
REQ-038 mem_req SHALL be forced 0 while resetn=0; an in-flight transaction SHALL be abandoned, and its late mem_ready ignored.
REQ-039 The first fetch SHALL request address RESET_PC in the first cycle after resetn deasserts.

Verification
REQ-040 Reset mid-MEMWR wait: pulse resetn low for 1 cycle -> mem_req drops in the same cycle, pc=RESET_PC, state=0, next mem_addr=RESET_PC.
REQ-041 Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 at zero-wait -> r3=2, r4=1, pc=0x10 after 16 cycles.
REQ-042 sw r3,8(r0) then lw r5,8(r0), with memory ready=0 for 3 cycles on each data access -> write addr 0x8 data 2 held stable for 4 cycles; r5=2; lw takes 8 cycles.
REQ-043 beq r1,r1,-2 at 0x20 -> pc=0x1C; beq r1,r2 not taken -> pc=0x24; each takes 3 cycles.
REQ-044 j 0x0000040 at pc 0x30000000 -> pc=0x30000100. Opcode 0x3F with HALT_ON_ILLEGAL=1 -> state=12, halted=1, mem_req stays 0; with HALT_ON_ILLEGAL=0 -> next fetch at old pc+4.
REQ-045 addi r0,r0,7 then add r6,r0,r0 -> r6=0.

Source files
------------

// File: rtl/cpu4_mc_datapath.sv
// Multicycle MIPS-subset core with one shared memory port. A three-process FSM
// sequences the PC/IR/A/B/ALUOUT/MDR datapath and the register file.
module cpu4_mc_datapath #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int          NREGS           = 32
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [3:0]  state,
    output logic        halted
);
    localparam int RIDX = $clog2(NREGS);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR = 6'h25, F_SLT = 6'h2A;

    state_t cur, nxt;
    logic [31:0] ir, a, b, aluout, mdr, alu, simm, wr_data;
    logic [31:0] rf [NREGS];
    logic [5:0]  op, funct;
    logic [RIDX-1:0] rs, rt, rd, wr_idx;
    logic legal_r, wr_en;

    assign op      = ir[31:26];
    assign funct   = ir[5:0];
    assign rs      = ir[21 +: RIDX];
    assign rt      = ir[16 +: RIDX];
    assign rd      = ir[11 +: RIDX];
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign legal_r = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                     (funct == F_OR)  || (funct == F_SLT);
    assign state   = cur;
    assign halted  = (cur == HALT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur <= FETCH;
        else         cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:  if (mem_ready) nxt = DECODE;
            DECODE: begin
                nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:    if (legal_r) nxt = EXEC;
                    OP_BEQ:  nxt = BRANCH;
                    OP_ADDI: nxt = ADDIEX;
                    OP_J:    nxt = JUMP;
                    default: ;
                endcase
            end
            MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) nxt = MEMWB;
            MEMWR:  if (mem_ready) nxt = FETCH;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    // Outputs depend on state and registers only; resetn gates the request.
    always_comb begin
        mem_req   = resetn && ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR));
        mem_we    = (cur == MEMWR);
        mem_addr  = (cur == FETCH) ? pc : aluout;
        mem_wdata = b;
    end

    always_comb begin
        case (funct)
            F_SUB:   alu = a - b;
            F_AND:   alu = a & b;
            F_OR:    alu = a | b;
            F_SLT:   alu = {31'b0, ($signed(a) < $signed(b))};
            default: alu = a + b;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rt;
        wr_data = aluout;
        case (cur)
            MEMWB:  begin wr_en = 1'b1; wr_data = mdr; end
            ALUWB:  begin wr_en = 1'b1; wr_idx = rd; end
            ADDIWB: wr_en = 1'b1;
            default: ;
        endcase
    end

    // Register 0 is never written, so it reads as zero forever after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_en && (wr_idx != '0)) begin
            rf[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            case (cur)
                FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    aluout <= pc + {simm[29:0], 2'b00};
                end
                MEMADR, ADDIEX: aluout <= a + simm;
                MEMRD:  if (mem_ready) mdr <= mem_rdata;
                EXEC:   aluout <= alu;
                BRANCH: if (a == b) pc <= aluout;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu4_mc_datapath.sv
// Directed bench: dut0 (defaults) runs a small program against a stalling memory;
// dut1 (RESET_PC=0x3000_0000, illegal-as-NOP) covers jump, NOP and mid-store reset.
module tb_cpu4_mc_datapath;
    localparam int DW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        resetn0, mem_req0, mem_we0, ready0, halted0;
    logic [31:0] mem_addr0, mem_wdata0, mem_rdata0, pc0;
    logic [3:0]  state0;
    logic        resetn1, mem_req1, mem_we1, ready1, halted1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1, pc1;
    logic [3:0]  state1;

    logic [31:0] prog0 [256];
    logic [31:0] dmem0 [256];
    bit          dvalid0 [256];
    logic [31:0] prog1 [256];
    int          wcnt0 = 0;

    cpu4_mc_datapath dut0 (
        .clk(clk), .resetn(resetn0), .mem_req(mem_req0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
        .mem_ready(ready0), .pc(pc0), .state(state0), .halted(halted0)
    );

    cpu4_mc_datapath #(.RESET_PC(32'h3000_0000), .HALT_ON_ILLEGAL(1'b0), .NREGS(32)) dut1 (
        .clk(clk), .resetn(resetn1), .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .mem_ready(ready1), .pc(pc1), .state(state1), .halted(halted1)
    );

    // dut0 memory: stored words overlay the program image; data accesses stall DW cycles
    assign mem_rdata0 = dvalid0[mem_addr0[9:2]] ? dmem0[mem_addr0[9:2]] : prog0[mem_addr0[9:2]];
    assign ready0     = !(mem_req0 && (state0 != 4'd0) && (wcnt0 < DW));
    assign mem_rdata1 = prog1[mem_addr1[9:2]];

    always @(posedge clk) begin
        if (mem_req0 && mem_we0 && ready0) begin
            dmem0[mem_addr0[9:2]]   <= mem_wdata0;
            dvalid0[mem_addr0[9:2]] <= 1'b1;
        end
        if (!resetn0 || !(mem_req0 && (state0 != 4'd0))) wcnt0 <= 0;
        else if (wcnt0 < DW)                            wcnt0 <= wcnt0 + 1;
        else                                            wcnt0 <= 0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH of a sw; checks the stalled store is held stable, then completes.
    task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
        tick(3);
        for (int k = 0; k <= DW; k++) begin
            chk({tag, " state"}, {28'b0, state0}, 32'd5);
            chk({tag, " we"},    {31'b0, mem_we0}, 32'd1);
            chk({tag, " addr"},  mem_addr0, addr);
            chk({tag, " wdata"}, mem_wdata0, data);
            tick(1);
        end
        chk({tag, " done"}, {28'b0, state0}, 32'd0);
    endtask

    initial begin
        resetn0 = 1'b0;
        resetn1 = 1'b0;
        ready1  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            prog0[i] = 32'h0;
            prog1[i] = 32'h0;
        end
        prog0[0]  = 32'h20010005; // addi r1,r0,5
        prog0[1]  = 32'h2002FFFD; // addi r2,r0,-3
        prog0[2]  = 32'h00221820; // add  r3,r1,r2
        prog0[3]  = 32'h0041202A; // slt  r4,r2,r1
        prog0[4]  = 32'hAC030008; // sw   r3,8(r0)
        prog0[5]  = 32'h8C050008; // lw   r5,8(r0)
        prog0[6]  = 32'hAC04000C; // sw   r4,12(r0)
        prog0[7]  = 32'hAC050010; // sw   r5,16(r0)
        prog0[8]  = 32'h1021FFFE; // beq  r1,r1,-2
        prog0[9]  = 32'h20000007; // addi r0,r0,7
        prog0[10] = 32'h00003020; // add  r6,r0,r0
        prog0[11] = 32'hAC060014; // sw   r6,20(r0)
        prog0[12] = 32'h00223822; // sub  r7,r1,r2
        prog0[13] = 32'h00474024; // and  r8,r2,r7
        prog0[14] = 32'h00274825; // or   r9,r1,r7
        prog0[15] = 32'h0022502A; // slt  r10,r1,r2
        prog0[16] = 32'hAC070080; // sw   r7,0x80(r0)
        prog0[17] = 32'hAC080084; // sw   r8,0x84(r0)
        prog0[18] = 32'hAC090088; // sw   r9,0x88(r0)
        prog0[19] = 32'hAC0A008C; // sw   r10,0x8C(r0)
        prog0[20] = 32'hFC000000; // illegal opcode 0x3F
        prog1[0]  = 32'h08000040; // j 0x0000040
        prog1[64] = 32'hFC000000; // illegal -> NOP
        prog1[65] = 32'hAC000010; // sw r0,0x10(r0)

        tick(2);
        chk("rst state", {28'b0, state0}, 32'd0);
        chk("rst pc", pc0, 32'h0);
        chk("rst halted", {31'b0, halted0}, 32'd0);
        chk("rst req", {31'b0, mem_req0}, 32'd0);
        resetn0 = 1'b1;
        #1;
        chk("first req", {31'b0, mem_req0}, 32'd1);
        chk("first addr", mem_addr0, 32'h0);
        chk("first we", {31'b0, mem_we0}, 32'd0);
        tick(1);
        chk("fetch0 state", {28'b0, state0}, 32'd1);
        chk("fetch0 pc", pc0, 32'h4);
        tick(15);
        chk("alu prog pc", pc0, 32'h10);
        chk("alu prog state", {28'b0, state0}, 32'd0);

        do_sw("sw r3", 32'h8, 32'h2);
        tick(7);
        chk("lw memwb", {28'b0, state0}, 32'd4);
        tick(1);
        chk("lw done pc", pc0, 32'h18);
        chk("lw done state", {28'b0, state0}, 32'd0);
        do_sw("sw r4", 32'hC, 32'h1);
        do_sw("sw r5", 32'h10, 32'h2);
        chk("dmem r3", dmem0[2], 32'h2);

        tick(2);
        chk("beq t state", {28'b0, state0}, 32'd8);
        tick(1);
        chk("beq t pc", pc0, 32'h1C);
        chk("beq t fetch", {28'b0, state0}, 32'd0);
        prog0[8] = 32'h1022FFFE; // beq r1,r2,-2 (not taken)
        do_sw("sw r5 again", 32'h10, 32'h2);
        tick(2);
        chk("beq nt state", {28'b0, state0}, 32'd8);
        tick(1);
        chk("beq nt pc", pc0, 32'h24);

        tick(8);
        chk("r0 prog pc", pc0, 32'h2C);
        do_sw("sw r6", 32'h14, 32'h0);
        tick(16);
        chk("alu2 pc", pc0, 32'h40);
        do_sw("sub", 32'h80, 32'h8);
        do_sw("and", 32'h84, 32'h8);
        do_sw("or", 32'h88, 32'hD);
        do_sw("slt false", 32'h8C, 32'h0);

        tick(2);
        chk("halt state", {28'b0, state0}, 32'd12);
        chk("halt flag", {31'b0, halted0}, 32'd1);
        chk("halt req", {31'b0, mem_req0}, 32'd0);
        chk("halt pc", pc0, 32'h54);
        tick(5);
        chk("halt stays", {28'b0, state0}, 32'd12);
        chk("halt req stays", {31'b0, mem_req0}, 32'd0);
        chk("halt pc stays", pc0, 32'h54);

        resetn1 = 1'b1;
        #1;
        chk("d1 first addr", mem_addr1, 32'h3000_0000);
        chk("d1 first req", {31'b0, mem_req1}, 32'd1);
        tick(3);
        chk("jump pc", pc1, 32'h3000_0100);
        chk("jump state", {28'b0, state1}, 32'd0);
        tick(2);
        chk("nop state", {28'b0, state1}, 32'd0);
        chk("nop addr", mem_addr1, 32'h3000_0104);
        chk("nop halted", {31'b0, halted1}, 32'd0);
        tick(1);
        ready1 = 1'b0;
        tick(2);
        chk("d1 memwr state", {28'b0, state1}, 32'd5);
        chk("d1 memwr we", {31'b0, mem_we1}, 32'd1);
        chk("d1 memwr wdata", mem_wdata1, 32'h0);
        tick(2);
        chk("d1 memwr wait", {28'b0, state1}, 32'd5);
        chk("d1 memwr addr", mem_addr1, 32'h10);
        resetn1 = 1'b0;
        #1;
        chk("rst req drop", {31'b0, mem_req1}, 32'd0);
        chk("rst pc1", pc1, 32'h3000_0000);
        chk("rst state1", {28'b0, state1}, 32'd0);
        ready1 = 1'b1;
        tick(1);
        resetn1 = 1'b1;
        #1;
        chk("post rst addr", mem_addr1, 32'h3000_0000);
        chk("post rst req", {31'b0, mem_req1}, 32'd1);
        tick(1);
        chk("post rst fetch pc", pc1, 32'h3000_0004);
        chk("post rst state", {28'b0, state1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
